// File: rtl/branch_ctrl_if.sv
// Comparator bus between the decode branch controller (master) and the
// branch comparator (slave): operands and op code out, result back.
interface branch_ctrl_if;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [5:0]  cmp_op;
    logic        cmp_y;

    modport master (output cmp_a, output cmp_b, output cmp_op, input cmp_y);
    modport slave  (input cmp_a, input cmp_b, input cmp_op, output cmp_y);
endinterface

// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: operand select/forward, hazard stall, PC-select,
// link, stall watchdog. Optional statistics counters under `BRANCH_STATS_EN.
module branch_ctrl #(
    parameter int STALL_LIMIT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        branch_valid,
    input  logic [5:0]  branch_op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_writereg,
    input  logic        mem_regwrite,
    input  logic        mem_memtoreg,
    input  logic [4:0]  mem_writereg,
    input  logic [31:0] mem_aluout,
    input  logic        d_hold,
    branch_ctrl_if.master cmp,
    output logic        stall_d,
    output logic        pc_src,
    output logic        link,
    output logic        stall_err,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_stall_cycles
);
    // Control codes, matching the encodings in defines2.vh.
    localparam logic [5:0] BEQ_CONTROL    = 6'b000100;
    localparam logic [5:0] BNE_CONTROL    = 6'b000101;
    localparam logic [5:0] BLTZAL_CONTROL = 6'b110000;
    localparam logic [5:0] BGEZAL_CONTROL = 6'b110001;

    localparam int CNT_W = $clog2(STALL_LIMIT + 2) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;

    logic        uses_rt;
    logic        hazard;
    logic        resolve;
    logic [4:0]  src  [2];
    logic [31:0] rdat [2];
    logic [31:0] opnd [2];
    logic [1:0]  used, haz, fwd;

    assign uses_rt = (branch_op == BEQ_CONTROL) || (branch_op == BNE_CONTROL);
    assign used    = {uses_rt, 1'b1};
    assign src[0]  = rs;
    assign src[1]  = rt;
    assign rdat[0] = rd1;
    assign rdat[1] = rd2;

    // A load still in MEM cannot be forwarded, and an EX producer always stalls.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign haz[gi] = used[gi] && (src[gi] != 5'd0) &&
                             ((ex_regwrite && (ex_writereg == src[gi])) ||
                              (mem_regwrite && mem_memtoreg && (mem_writereg == src[gi])));
            assign fwd[gi] = used[gi] && (src[gi] != 5'd0) && mem_regwrite &&
                             !mem_memtoreg && (mem_writereg == src[gi]);
            assign opnd[gi] = fwd[gi] ? mem_aluout : rdat[gi];
        end
    endgenerate

    assign hazard     = |haz;
    assign cmp.cmp_a  = opnd[0];
    assign cmp.cmp_b  = opnd[1];
    assign cmp.cmp_op = branch_op;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (branch_valid && hazard) begin
                    state_next = WAIT;
                    cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_next = '0;
                end
            end
            WAIT: begin
                if (!branch_valid || !hazard) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        err_next = err_reg || (cnt_next > LIMIT);
    end

    // Outputs are gated by resetn so a reset mid-stall releases decode at once.
    always_comb begin
        stall_d = resetn && branch_valid && hazard;
        resolve = resetn && branch_valid && !hazard;
        pc_src  = resolve && cmp.cmp_y;
        link    = resolve && ((branch_op == BLTZAL_CONTROL) || (branch_op == BGEZAL_CONTROL));
    end

    assign stall_err = err_reg;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_reg, tk_reg, st_reg;
    logic        counted;

    // A held branch resolves repeatedly; only the releasing cycle is counted.
    assign counted = resolve && !d_hold;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_reg <= '0;
            tk_reg <= '0;
            st_reg <= '0;
        end else begin
            if (counted)
                br_reg <= br_reg + 32'd1;
            if (counted && pc_src)
                tk_reg <= tk_reg + 32'd1;
            if (stall_d)
                st_reg <= st_reg + 32'd1;
        end
    end

    assign stat_branches     = br_reg;
    assign stat_taken        = tk_reg;
    assign stat_stall_cycles = st_reg;
`else
    logic unused_hold;
    assign unused_hold       = d_hold;
    assign stat_branches     = 32'd0;
    assign stat_taken        = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: bench acts as the comparator and the
// surrounding pipeline, expected values are hand-computed per vector.
module tb_branch_ctrl;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLTZ   = 6'b100000;
    localparam logic [5:0] OP_BGEZAL = 6'b110001;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        branch_valid;
    logic [5:0]  branch_op;
    logic [4:0]  rs, rt;
    logic [31:0] rd1, rd2;
    logic        ex_regwrite;
    logic [4:0]  ex_writereg;
    logic        mem_regwrite, mem_memtoreg;
    logic [4:0]  mem_writereg;
    logic [31:0] mem_aluout;
    logic        d_hold;
    logic        stall_d, pc_src, link, stall_err;
    logic [31:0] stat_branches, stat_taken, stat_stall_cycles;

    int checks = 0;
    int failures = 0;

    branch_ctrl_if bus ();

    branch_ctrl #(.STALL_LIMIT(3)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .branch_valid      (branch_valid),
        .branch_op         (branch_op),
        .rs                (rs),
        .rt                (rt),
        .rd1               (rd1),
        .rd2               (rd2),
        .ex_regwrite       (ex_regwrite),
        .ex_writereg       (ex_writereg),
        .mem_regwrite      (mem_regwrite),
        .mem_memtoreg      (mem_memtoreg),
        .mem_writereg      (mem_writereg),
        .mem_aluout        (mem_aluout),
        .d_hold            (d_hold),
        .cmp               (bus.master),
        .stall_d           (stall_d),
        .pc_src            (pc_src),
        .link              (link),
        .stall_err         (stall_err),
        .stat_branches     (stat_branches),
        .stat_taken        (stat_taken),
        .stat_stall_cycles (stat_stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] st(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        branch_valid = 1'b0; branch_op = 6'd0; rs = 5'd0; rt = 5'd0;
        rd1 = 32'd0; rd2 = 32'd0; ex_regwrite = 1'b0; ex_writereg = 5'd0;
        mem_regwrite = 1'b0; mem_memtoreg = 1'b0; mem_writereg = 5'd0;
        mem_aluout = 32'd0; d_hold = 1'b0; bus.cmp_y = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1;
        do_reset();

        // Reset state
        settle();
        check("rst_stall_d", 32'(stall_d), 32'd0);
        check("rst_pc_src", 32'(pc_src), 32'd0);
        check("rst_link", 32'(link), 32'd0);
        check("rst_stall_err", 32'(stall_err), 32'd0);
        check("rst_branches", stat_branches, 32'd0);

        // BEQ, no hazard, taken in the same cycle
        branch_valid = 1'b1; branch_op = OP_BEQ; rs = 5'd2; rt = 5'd3;
        rd1 = 32'd5; rd2 = 32'd5; bus.cmp_y = 1'b1;
        settle();
        check("beq_pc_src", 32'(pc_src), 32'd1);
        check("beq_stall_d", 32'(stall_d), 32'd0);
        check("beq_link", 32'(link), 32'd0);
        check("beq_cmp_a", bus.cmp_a, 32'd5);
        check("beq_cmp_op", 32'(bus.cmp_op), 32'(OP_BEQ));
        tick();
        check("beq_branches", stat_branches, st(1));
        check("beq_taken", stat_taken, st(1));

        // BNE with EX ALU op writing rt: one stall then MEM forward
        do_reset();
        branch_valid = 1'b1; branch_op = OP_BNE; rs = 5'd2; rt = 5'd3;
        rd1 = 32'd7; rd2 = 32'd9; ex_regwrite = 1'b1; ex_writereg = 5'd3; bus.cmp_y = 1'b1;
        settle();
        check("bne_c0_stall_d", 32'(stall_d), 32'd1);
        check("bne_c0_pc_src", 32'(pc_src), 32'd0);
        tick();
        ex_regwrite = 1'b0; mem_regwrite = 1'b1; mem_memtoreg = 1'b0;
        mem_writereg = 5'd3; mem_aluout = 32'h1234;
        settle();
        check("bne_c1_cmp_b", bus.cmp_b, 32'h1234);
        check("bne_c1_cmp_a", bus.cmp_a, 32'd7);
        check("bne_c1_stall_d", 32'(stall_d), 32'd0);
        check("bne_c1_pc_src", 32'(pc_src), 32'd1);
        tick();
        idle_inputs();
        check("bne_stall_cycles", stat_stall_cycles, st(1));
        check("bne_branches", stat_branches, st(1));

        // BGEZAL, load in EX writing r4: two stalls then link, not taken
        do_reset();
        branch_valid = 1'b1; branch_op = OP_BGEZAL; rs = 5'd4; rt = 5'd0;
        ex_regwrite = 1'b1; ex_writereg = 5'd4; bus.cmp_y = 1'b0;
        settle();
        check("bgezal_c0_stall_d", 32'(stall_d), 32'd1);
        tick();
        ex_regwrite = 1'b0; mem_regwrite = 1'b1; mem_memtoreg = 1'b1; mem_writereg = 5'd4;
        settle();
        check("bgezal_c1_stall_d", 32'(stall_d), 32'd1);
        tick();
        mem_regwrite = 1'b0; mem_memtoreg = 1'b0; mem_writereg = 5'd0; rd1 = 32'hFFFF_FFF0;
        settle();
        check("bgezal_c2_stall_d", 32'(stall_d), 32'd0);
        check("bgezal_c2_link", 32'(link), 32'd1);
        check("bgezal_c2_pc_src", 32'(pc_src), 32'd0);
        check("bgezal_c2_cmp_a", bus.cmp_a, 32'hFFFF_FFF0);
        tick();
        idle_inputs();
        check("bgezal_stall_cycles", stat_stall_cycles, st(2));
        check("bgezal_taken", stat_taken, st(0));

        // r0 never hazards; rt ignored for single-operand ops
        do_reset();
        branch_valid = 1'b1; branch_op = OP_BLTZ; rs = 5'd0; rt = 5'd0;
        ex_regwrite = 1'b1; ex_writereg = 5'd0; rd2 = 32'h55;
        settle();
        check("r0_stall_d", 32'(stall_d), 32'd0);
        check("bltz_cmp_b_rd2", bus.cmp_b, 32'h55);
        rs = 5'd5; rt = 5'd3; ex_writereg = 5'd3;
        settle();
        check("bltz_rt_unused", 32'(stall_d), 32'd0);
        check("bltz_link", 32'(link), 32'd0);
        idle_inputs();

        // Watchdog: hazard held 5 cycles with STALL_LIMIT=3
        do_reset();
        branch_valid = 1'b1; branch_op = OP_BEQ; rs = 5'd6; rt = 5'd7;
        ex_regwrite = 1'b1; ex_writereg = 5'd6;
        tick(); tick(); tick();
        check("wd_err_after3", 32'(stall_err), 32'd0);
        tick();
        check("wd_err_after4", 32'(stall_err), 32'd1);
        tick();
        ex_regwrite = 1'b0;
        settle();
        check("wd_resolve_stall_d", 32'(stall_d), 32'd0);
        tick();
        idle_inputs();
        tick();
        check("wd_err_sticky", 32'(stall_err), 32'd1);
        check("wd_stall_cycles", stat_stall_cycles, st(5));

        // Flush during WAIT: no resolve, no counter update
        do_reset();
        branch_valid = 1'b1; branch_op = OP_BEQ; rs = 5'd8; rt = 5'd9;
        ex_regwrite = 1'b1; ex_writereg = 5'd9; bus.cmp_y = 1'b1;
        tick();
        branch_valid = 1'b0;
        settle();
        check("flush_stall_d", 32'(stall_d), 32'd0);
        check("flush_pc_src", 32'(pc_src), 32'd0);
        tick();
        check("flush_branches", stat_branches, 32'd0);
        check("flush_stall_cycles", stat_stall_cycles, st(1));
        ex_regwrite = 1'b0; branch_valid = 1'b1;
        settle();
        check("flush_next_resolve", 32'(pc_src), 32'd1);
        idle_inputs();

        // Reset pulsed during WAIT
        do_reset();
        branch_valid = 1'b1; branch_op = OP_BEQ; rs = 5'd10; rt = 5'd11;
        ex_regwrite = 1'b1; ex_writereg = 5'd10;
        tick(); tick();
        check("rstw_pre_stall_cycles", stat_stall_cycles, st(2));
        resetn = 1'b0;
        settle();
        check("rstw_stall_d", 32'(stall_d), 32'd0);
        check("rstw_stall_cycles", stat_stall_cycles, 32'd0);
        check("rstw_branches", stat_branches, 32'd0);
        idle_inputs();
        tick();
        resetn = 1'b1;

        // d_hold: outputs driven, statistics counted once on release
        branch_valid = 1'b1; branch_op = OP_BEQ; rs = 5'd1; rt = 5'd1;
        d_hold = 1'b1; bus.cmp_y = 1'b1;
        settle();
        check("hold_pc_src", 32'(pc_src), 32'd1);
        tick();
        tick();
        check("hold_branches", stat_branches, 32'd0);
        d_hold = 1'b0;
        tick();
        idle_inputs();
        check("hold_release_branches", stat_branches, st(1));
        check("hold_release_taken", stat_taken, st(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

- Decode-stage branch controller for the MIPS pipeline.
- Sequences the branch comparator:
  - drives its operands (register file data or MEM-stage forward) and its op code;
  - stalls decode while an operand is still in flight;
  - samples the compare result and produces the PC-select and link controls.
- Also keeps a stall watchdog and optional branch statistics.
- Sits between the register file / hazard inputs and the fetch PC mux.

## Interface
- `STALL_LIMIT`, default 3: stall cycles one branch may accumulate before `stall_err` sets.
- `clk` in 1: clock; all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `branch_valid` in 1: decode holds a branch instruction.
- `branch_op` in 6: branch control code.
  - Values: `BEQ_CONTROL`, `BNE_CONTROL`, `BGTZ_CONTROL`, `BLEZ_CONTROL`, `BLTZ_CONTROL`, `BLTZAL_CONTROL`, `BGEZ_CONTROL`, `BGEZAL_CONTROL`.
  - Encodings come from defines2.vh.
- `rs`, `rt` in 5: source register numbers.
- `rd1`, `rd2` in 32: register file read data for rs, rt.
- `ex_regwrite` in 1, `ex_writereg` in 5: EX-stage destination.
- `mem_regwrite` in 1, `mem_memtoreg` in 1, `mem_writereg` in 5, `mem_aluout` in 32: MEM-stage destination and ALU result.
- `d_hold` in 1: external decode stall (e.g. cache miss); the branch stays in D.
- `cmp_a`, `cmp_b` out 32: comparator operands.
- `cmp_op` out 6: comparator op code, equal to `branch_op`.
- `cmp_y` in 1: comparator result.
- `stall_d` out 1: stall fetch/decode and insert a bubble into EX.
- `pc_src` out 1: select the branch target.
- `link` out 1: write PC+8 to r31.
- `stall_err` out 1: sticky watchdog flag.
- `stat_branches`, `stat_taken`, `stat_stall_cycles` out 32 each: statistics counters.

## Operation
- **rt usage**
  - rt is used only for BEQ and BNE.
  - The other ops compare rs alone; `cmp_b` is a don't-care and is driven with `rd2`.
- **Hazard on source s** (s = rs, or rt when used), with s ≠ 0:
  - `ex_regwrite` and `ex_writereg` == s, or
  - `mem_regwrite` and `mem_memtoreg` and `mem_writereg` == s.
- **Forwarding:**
  - If `mem_regwrite`, not `mem_memtoreg`, and `mem_writereg` == s ≠ 0, the operand is `mem_aluout`.
  - Otherwise the operand is `rd1` / `rd2`.
  - An EX match takes priority: it stalls, it does not forward.
- **FSM states:**
  - IDLE:
    - `branch_valid` & hazard → WAIT, `stall_cnt` = 1, `stall_d` = 1.
    - `branch_valid` & no hazard → resolve this cycle, stay IDLE.
  - WAIT:
    - hazard persists → `stall_d` = 1, `stall_cnt` saturating increment.
    - hazard clears → resolve this cycle → IDLE.
    - `branch_valid` drops (pipeline flush) → IDLE, no resolve, no outputs asserted.
- **Resolve cycle** (combinational, no hazard, `branch_valid` = 1):
  - `stall_d` = 0.
  - `pc_src` = `cmp_y`.
  - `link` = 1 for BLTZAL / BGEZAL regardless of `cmp_y`, else 0.
- **`d_hold`** = 1 in a resolve cycle:
  - `pc_src` and `link` are still driven;
  - statistics are not updated until the cycle with `d_hold` = 0, so each branch counts once.
- **Watchdog:** `stall_cnt` > `STALL_LIMIT` sets `stall_err`; it clears only on reset.
- **No branch:** with `branch_valid` = 0, `stall_d`, `pc_src` and `link` are 0.

## Timing
- Reset values:
  - state IDLE, `stall_cnt` 0, `stall_err` 0, all `stat_*` 0;
  - combinational outputs follow the rules above (0 with no branch).
- Resolve latency:
  - 0 cycles with no hazard;
  - hazard from EX ALU op: 1 stall cycle (then MEM forward);
  - load in EX: 2 stall cycles;
  - load in MEM: 1 stall cycle.
- Reset asserted mid-WAIT: immediate return to IDLE, `stall_d` drops the same cycle.
- Counters wrap at 2^32.

## Configuration
- Macro `BRANCH_STATS_EN`.
- Defined:
  - `stat_branches` increments on each counted resolve;
  - `stat_taken` increments when the counted resolve has `pc_src` = 1;
  - `stat_stall_cycles` increments every cycle with `stall_d` = 1.
- Undefined: the counters are not built; `stat_*` ports are tied to 0.

## Test plan
- BEQ, rs=2, rt=3, `rd1`=`rd2`=5, no hazards, `cmp_y`=1 → same cycle: `pc_src`=1, `stall_d`=0, `link`=0; `stat_branches`=1, `stat_taken`=1.
- BNE with EX writing rt=3 (ALU op):
  - cycle 0: `stall_d`=1.
  - cycle 1: MEM ALU match → `cmp_b`=`mem_aluout`=0x1234, `stall_d`=0, `pc_src`=`cmp_y`.
  - `stat_stall_cycles`=1.
- BGEZAL, rs=4, load in EX writing r4 → 2 stall cycles, then `link`=1 with `cmp_y`=0 (`pc_src`=0).
- rs=0 with `ex_writereg`=0 and `ex_regwrite`=1 → no stall.
- Forced hazard held 5 cycles with `STALL_LIMIT`=3 → `stall_err` rises after cycle 4 and stays 1 after the hazard clears.
- `branch_valid` dropped during WAIT → next cycle IDLE, no counter update.
- `resetn` pulsed low during WAIT → IDLE, all counters 0.
